// File: rtl/lsu_ram_port.sv
// RV32 load/store adapter for a single-port byte-lane synchronous RAM.
// One request in flight; each request yields exactly one registered response.
`timescale 1ns/1ps

module lsu_ram_port #(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH+1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [3:0]            ram_we,
  output logic [31:0]           ram_wdata,
  input  logic [31:0]           ram_q
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  store_q, store_d;
  logic [1:0]            size_q, size_d;
  logic                  unsigned_q, unsigned_d;
  logic [1:0]            lane_q, lane_d;
  logic [3:0]            we_mask_q, we_mask_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [31:0]           ram_wdata_q, ram_wdata_d;

  // Incoming request decode
  logic        req_bad;
  logic [3:0]  req_mask;
  logic [31:0] req_wrep;

  always_comb begin
    req_bad  = 1'b0;
    req_mask = 4'b0000;
    req_wrep = req_wdata;
    case (req_size)
      2'b00: begin
        req_mask = 4'b0001 << req_addr[1:0];
        req_wrep = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        req_bad  = req_addr[0];
        req_mask = 4'b0011 << {req_addr[1], 1'b0};
        req_wrep = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        req_bad  = (req_addr[1:0] != 2'b00);
        req_mask = 4'hF;
        req_wrep = req_wdata;
      end
      default: begin
        req_bad  = 1'b1;
        req_mask = 4'b0000;
      end
    endcase
    if (!req_we) begin
      req_mask = 4'b0000;
    end
  end

  // Load data lane select and extension
  logic [7:0]  q_byte [4];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_ext;

  for (genvar gi = 0; gi < 4; gi++) begin : g_qbyte
    assign q_byte[gi] = ram_q[8*gi +: 8];
  end

  always_comb begin
    sel_byte = q_byte[lane_q];
    sel_half = lane_q[1] ? ram_q[31:16] : ram_q[15:0];
    case (size_q)
      2'b00:   load_ext = {{24{!unsigned_q & sel_byte[7]}}, sel_byte};
      2'b01:   load_ext = {{16{!unsigned_q & sel_half[15]}}, sel_half};
      default: load_ext = ram_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    store_d     = store_q;
    size_d      = size_q;
    unsigned_d  = unsigned_q;
    lane_d      = lane_q;
    we_mask_d   = we_mask_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          store_d    = req_we;
          size_d     = req_size;
          unsigned_d = req_unsigned;
          lane_d     = req_addr[1:0];
          rdata_d    = 32'h0;
          err_d      = req_bad;
          if (req_bad) begin
            we_mask_d = 4'b0000;
            state_d   = S_RESP;
          end else begin
            // RAM-side registers only move for legal requests
            we_mask_d   = req_mask;
            ram_addr_d  = req_addr[ADDR_WIDTH+1:2];
            ram_wdata_d = req_wrep;
            state_d     = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        state_d = store_q ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        rdata_d = load_ext;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      store_q     <= 1'b0;
      size_q      <= 2'b00;
      unsigned_q  <= 1'b0;
      lane_q      <= 2'b00;
      we_mask_q   <= 4'b0000;
      rdata_q     <= 32'h0;
      err_q       <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      store_q     <= store_d;
      size_q      <= size_d;
      unsigned_q  <= unsigned_d;
      lane_q      <= lane_d;
      we_mask_q   <= we_mask_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  // Reset gates the strobe combinationally so a write caught mid-ISSUE never lands
  assign ram_we    = (state_q == S_ISSUE && !reset) ? we_mask_q : 4'b0000;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign req_ready = (state_q == S_IDLE) && !reset;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_lsu_ram_port.sv
// Self-checking bench for lsu_ram_port: directed vector table, corner sequences,
// and random traffic against a byte-array memory model.
`timescale 1ns/1ps

module tb_lsu_ram_port;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [AW+1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] ram_addr;
  logic [3:0]    ram_we;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_q;

  always #5 clk = ~clk;

  lsu_ram_port #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .ram_addr(ram_addr),
    .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_q(ram_q)
  );

  // Attached RAM: byte-lane writes, one-cycle registered read
  logic        ram_init;
  logic [31:0] ram_mem [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < (1 << AW); i++) ram_mem[i] <= 32'h0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (ram_we[i]) ram_mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
    end
    ram_q <= ram_mem[ram_addr];
  end

  // Reference memory, byte addressed
  logic [7:0] ref_mem [0:255];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] size);
    return 1 << size;
  endfunction

  function automatic logic model_err(input logic [7:0] addr, input logic [1:0] size);
    if (size == 2'd3) return 1'b1;
    return (int'(addr) % nbytes(size)) != 0;
  endfunction

  function automatic logic [3:0] model_mask(input logic [7:0] addr, input logic [1:0] size);
    int nb = nbytes(size);
    return 4'(((1 << nb) - 1) << (int'(addr) % 4));
  endfunction

  function automatic logic [31:0] model_wrep(input logic [31:0] wd, input logic [1:0] size);
    if (size == 2'd0) return {24'h0, wd[7:0]} * 32'h01010101;
    if (size == 2'd1) return {16'h0, wd[15:0]} * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] model_load(input logic [7:0] addr, input logic [1:0] size,
                                             input logic uns);
    int nb = nbytes(size);
    logic [31:0] v = 32'h0;
    logic [31:0] top;
    for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[int'(addr) + i]) << (8 * i));
    if (!uns && nb < 4) begin
      top = 32'h1 << (8 * nb - 1);
      if ((v & top) != 0) v = v | ~((top << 1) - 1);
    end
    return v;
  endfunction

  task automatic model_store(input logic [7:0] addr, input logic [1:0] size, input logic [31:0] wd);
    for (int i = 0; i < nbytes(size); i++) ref_mem[int'(addr) + i] = 8'(wd >> (8 * i));
  endtask

  // Issue one request with rsp_ready high; check timing, RAM strobes and response
  task automatic run_txn(input string tag, input logic we, input logic [1:0] size,
                         input logic uns, input logic [7:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input logic [3:0] exp_we, input logic [31:0] exp_wdata);
    int exp_lat = exp_err ? 1 : (we ? 2 : 3);
    int lat = 0;
    int we_cnt = 0;
    int we_cyc = 0;
    logic [3:0]    got_we = 4'h0;
    logic [31:0]   got_wd = 32'h0;
    logic [AW-1:0] got_ra = '0;
    logic [AW-1:0] addr_k1 = '0;
    logic [31:0]   rd = 32'h0;
    logic          er = 1'b0;
    chk({tag, " req_ready idle"}, 32'(req_ready), 32'h1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wd; rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (k == 1) addr_k1 = ram_addr;
      if (ram_we != 4'h0) begin
        we_cnt++; we_cyc = k; got_we = ram_we; got_wd = ram_wdata; got_ra = ram_addr;
      end
      if (rsp_valid) begin
        lat = k; rd = rsp_rdata; er = rsp_err;
        break;
      end
      @(posedge clk); #1;
    end
    if (lat == 0) begin
      n_checks++; n_fail++;
      $display("FAIL %s timeout: no rsp_valid within 8 cycles", tag);
    end else begin
      chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
      chk({tag, " rdata"}, rd, exp_rdata);
      chk({tag, " err"}, 32'(er), 32'(exp_err));
    end
    chk({tag, " we_count"}, 32'(we_cnt), (exp_we != 4'h0) ? 32'h1 : 32'h0);
    if (exp_we != 4'h0) begin
      chk({tag, " we_cycle"}, 32'(we_cyc), 32'h1);
      chk({tag, " ram_we"}, 32'(got_we), 32'(exp_we));
      chk({tag, " ram_wdata"}, got_wd, exp_wdata);
      chk({tag, " ram_addr_we"}, 32'(got_ra), 32'(addr[7:2]));
    end
    if (!exp_err) chk({tag, " ram_addr"}, 32'(addr_k1), 32'(addr[7:2]));
    $display("txn %s we=%0d size=%0d uns=%0d addr=0x%02h wdata=0x%08h -> rdata=0x%08h err=%0d lat=%0d",
             tag, we, size, uns, addr, wd, rd, er, lat);
    if (we && !exp_err) model_store(addr, size, wd);
    @(posedge clk); #1;
  endtask

  typedef struct {
    string       tag;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [3:0]  exp_we;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs [17];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held;
    int waited;

    vecs[0]  = '{"SW08",   1, 2'd2, 0, 8'h08, 32'hDEADBEEF, 32'h0,        0, 4'hF,    32'hDEADBEEF};
    vecs[1]  = '{"LW08",   0, 2'd2, 0, 8'h08, 32'h0,        32'hDEADBEEF, 0, 4'h0,    32'h0};
    vecs[2]  = '{"SW0C",   1, 2'd2, 0, 8'h0C, 32'h11223344, 32'h0,        0, 4'hF,    32'h11223344};
    vecs[3]  = '{"SB0D",   1, 2'd0, 0, 8'h0D, 32'h12345680, 32'h0,        0, 4'b0010, 32'h80808080};
    vecs[4]  = '{"LB0D",   0, 2'd0, 0, 8'h0D, 32'h0,        32'hFFFFFF80, 0, 4'h0,    32'h0};
    vecs[5]  = '{"LBU0D",  0, 2'd0, 1, 8'h0D, 32'h0,        32'h00000080, 0, 4'h0,    32'h0};
    vecs[6]  = '{"LW0C",   0, 2'd2, 0, 8'h0C, 32'h0,        32'h11228044, 0, 4'h0,    32'h0};
    vecs[7]  = '{"SH12",   1, 2'd1, 0, 8'h12, 32'hABCD8001, 32'h0,        0, 4'b1100, 32'h80018001};
    vecs[8]  = '{"LH12",   0, 2'd1, 0, 8'h12, 32'h0,        32'hFFFF8001, 0, 4'h0,    32'h0};
    vecs[9]  = '{"LHU12",  0, 2'd1, 1, 8'h12, 32'h0,        32'h00008001, 0, 4'h0,    32'h0};
    vecs[10] = '{"LW10",   0, 2'd2, 0, 8'h10, 32'h0,        32'h80010000, 0, 4'h0,    32'h0};
    vecs[11] = '{"LB12",   0, 2'd0, 0, 8'h12, 32'h0,        32'h00000001, 0, 4'h0,    32'h0};
    vecs[12] = '{"SB0F",   1, 2'd0, 0, 8'h0F, 32'h0000007F, 32'h0,        0, 4'b1000, 32'h7F7F7F7F};
    vecs[13] = '{"LB0F",   0, 2'd0, 0, 8'h0F, 32'h0,        32'h0000007F, 0, 4'h0,    32'h0};
    vecs[14] = '{"ELH05",  0, 2'd1, 0, 8'h05, 32'h0,        32'h0,        1, 4'h0,    32'h0};
    vecs[15] = '{"ESW06",  1, 2'd2, 0, 8'h06, 32'h55AA55AA, 32'h0,        1, 4'h0,    32'h0};
    vecs[16] = '{"ESZ3",   1, 2'd3, 0, 8'h00, 32'hFFFFFFFF, 32'h0,        1, 4'h0,    32'h0};

    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;

    // Reset held two cycles with a request pending
    reset = 1'b1; ram_init = 1'b1; rsp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 8'h08; req_wdata = 32'hFFFFFFFF;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      chk("rst req_ready", 32'(req_ready), 32'h0);
      chk("rst rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst rsp_rdata", rsp_rdata, 32'h0);
      chk("rst rsp_err", 32'(rsp_err), 32'h0);
      chk("rst ram_addr", 32'(ram_addr), 32'h0);
      chk("rst ram_we", 32'(ram_we), 32'h0);
      chk("rst ram_wdata", ram_wdata, 32'h0);
    end
    req_valid = 1'b0; reset = 1'b0; ram_init = 1'b0;
    @(posedge clk); #1;
    chk("post-rst req_ready", 32'(req_ready), 32'h1);

    foreach (vecs[i])
      run_txn(vecs[i].tag, vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
              vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].exp_we, vecs[i].exp_wdata);

    // Response back-pressure: hold rsp_ready low for 5 cycles in RESP
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 8'h08; rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    waited = 0;
    while (!rsp_valid && waited < 8) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("hold reached", 32'(rsp_valid), 32'h1);
    held = rsp_rdata;
    chk("hold rdata", held, model_load(8'h08, 2'd2, 1'b0));
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("hold rsp_valid", 32'(rsp_valid), 32'h1);
      chk("hold rdata stable", rsp_rdata, held);
      chk("hold req_ready", 32'(req_ready), 32'h0);
      chk("hold ram_we", 32'(ram_we), 32'h0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("hold released rsp_valid", 32'(rsp_valid), 32'h0);
    chk("hold released req_ready", 32'(req_ready), 32'h1);
    $display("txn HOLD load 0x08 held 5 cycles rdata=0x%08h", held);

    // Reset asserted during ISSUE of a store: write suppressed, no response
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 8'h08;
    req_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rstissue in_issue ram_we", 32'(ram_we), 32'hF);
    reset = 1'b1;
    #1;
    chk("rstissue ram_we gated", 32'(ram_we), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("rstissue no rsp", 32'(rsp_valid), 32'h0);
      chk("rstissue no we", 32'(ram_we), 32'h0);
      @(posedge clk); #1;
    end
    $display("txn RSTISSUE store 0x08 discarded");
    run_txn("LW08post", 1'b0, 2'd2, 1'b0, 8'h08, 32'h0, model_load(8'h08, 2'd2, 1'b0),
            1'b0, 4'h0, 32'h0);

    // Random traffic against the byte-array model
    for (int n = 0; n < 80; n++) begin
      logic        r_we, r_uns, r_err;
      logic [1:0]  r_size;
      logic [7:0]  r_addr;
      logic [31:0] r_wd, r_rd, r_xwd;
      logic [3:0]  r_mask;
      r_we   = 1'($urandom_range(0, 1));
      r_uns  = 1'($urandom_range(0, 1));
      r_size = 2'($urandom_range(0, 3));
      r_addr = 8'($urandom_range(0, 255));
      r_wd   = $urandom;
      if ($urandom_range(0, 3) != 0 && r_size != 2'd3)
        r_addr = 8'((int'(r_addr) / nbytes(r_size)) * nbytes(r_size));
      r_err  = model_err(r_addr, r_size);
      r_rd   = 32'h0;
      r_mask = 4'h0;
      r_xwd  = 32'h0;
      if (!r_err) begin
        if (r_we) begin
          r_mask = model_mask(r_addr, r_size);
          r_xwd  = model_wrep(r_wd, r_size);
        end else begin
          r_rd = model_load(r_addr, r_size, r_uns);
        end
      end
      run_txn($sformatf("R%0d", n), r_we, r_size, r_uns, r_addr, r_wd, r_rd, r_err, r_mask, r_xwd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_ram_port.md
# lsu_ram_port

Load/store adapter sitting directly upstream of the shared byte-lane RAM: it accepts one RV32 load or store per valid/ready handshake, converts the byte address and access size into a word address plus per-lane write enables with replicated write data, waits out the RAM's one-cycle synchronous read, then lane-selects and sign/zero-extends load data. It drives one RAM port (`ram_*` connects to the `addr_x/we_x/data_x/q_x` port of the RAM) and returns a single registered response per request, flagging misaligned or illegal-size accesses without touching memory.

## Interface
- ADDR_WIDTH, 6, word-address width of the attached RAM; byte address is ADDR_WIDTH+2 bits
- clk  in  1  sole clock; RAM shares it
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block accepts request this cycle
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  zero-extend load (LBU/LHU); ignored for word/stores
- req_addr  in  ADDR_WIDTH+2  byte address
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned or illegal size
- ram_addr  out  ADDR_WIDTH  word address = req_addr[ADDR_WIDTH+1:2]
- ram_we  out  4  per-byte write enables, bit i = bits [8i+7:8i]
- ram_wdata  out  32  lane-replicated store data
- ram_q  in  32  RAM read data, valid one cycle after ram_addr

## Operation
- States: IDLE, ISSUE, WAIT, RESP. req_ready = (state==IDLE) & !reset.
- IDLE: on req_valid, latch all request fields. Size 11, or half with addr[0]=1, or word with addr[1:0]!=0 -> RESP with rsp_err=1, rsp_rdata=0, no RAM cycle. Else -> ISSUE.
- ISSUE (exactly one cycle): ram_addr/ram_wdata/ram_we driven from registers. Store: SB we=4'b0001<<addr[1:0], wdata={4{wdata[7:0]}}; SH we=4'b0011<<{addr[1],1'b0}, wdata={2{wdata[15:0]}}; SW we=4'hF, wdata=wdata. Load: we=0. Store -> RESP (rdata=0, err=0); load -> WAIT.
- WAIT: ram_q valid; select byte addr[1:0] or half addr[1]; sign-extend unless req_unsigned; register into rsp_rdata; -> RESP.
- RESP: rsp_valid=1, rdata/err stable until rsp_valid&rsp_ready, then -> IDLE. No new request accepted in same cycle (req_ready low in RESP).
- ram_we nonzero only in ISSUE; ram_addr/ram_wdata hold last value otherwise.
- Reset mid-transaction: request discarded, no response emitted; if asserted during ISSUE the write in that cycle is suppressed (ram_we forced 0 while reset).

## Timing
- Reset values: state IDLE, rsp_valid 0, rsp_rdata 0, rsp_err 0, ram_addr 0, ram_we 0, ram_wdata 0; req_ready 0 while reset high, 1 the cycle after.
- Accept at edge T: store -> ram_we asserted cycle T+1, rsp_valid T+2; load -> ram_addr T+1, ram_q T+2, rsp_valid T+3; error -> rsp_valid T+1.
- Throughput with rsp_ready tied high: store 1 per 3 cycles, load 1 per 4.
- rsp_ready low holds RESP indefinitely; all outputs stable.
- One request outstanding maximum; load after store to same word sees new data (write completes before next ISSUE).

## Test plan
- Reset: assert reset 2 cycles with req_valid=1 -> req_ready=0, all outputs 0, no ram_we; after release req_ready=1.
- SW 0xDEADBEEF @0x08, then LW @0x08 -> ram_we=4'hF at addr 2 on T+1, store rsp_valid at T+2; load rsp_rdata=0xDEADBEEF at T+3, err=0.
- SB 0x80 @0x0D, LB @0x0D -> ram_we=4'b0010, ram_wdata=0x80808080; rdata=0xFFFFFF80; LBU @0x0D -> 0x00000080; neighbouring bytes of word 3 unchanged.
- SH 0x8001 @0x12, LH @0x12 -> ram_we=4'b1100, wdata=0x80018001; rdata=0xFFFF8001; LHU -> 0x00008001.
- LH @0x05, SW @0x06, size 11 @0x00 -> rsp_valid at T+1, rsp_err=1, rdata=0, ram_we never asserted.
- rsp_ready held low 5 cycles in RESP -> rsp_valid/rdata stable, req_ready=0; reset during ISSUE of SW -> ram_we stays 0, no response.
